// File: rtl/systolic_array_ctrl_if.sv
// Host, array and consumer signals of the systolic array job sequencer.
// Latency: none, wiring only.
// Backpressure: in_ready throttles loads; out_ready throttles result rows.
interface systolic_array_ctrl_if #(
  parameter int N_SIZE    = 5,
  parameter int DATAWIDTH = 16
);
  logic                                      in_valid;
  logic                                      in_ready;
  logic signed [N_SIZE-1:0][DATAWIDTH-1:0]   in_a_row;
  logic signed [N_SIZE-1:0][DATAWIDTH-1:0]   in_b_row;
  logic                                      sa_valid_in;
  logic signed [N_SIZE-1:0][DATAWIDTH-1:0]   sa_a_row;
  logic signed [N_SIZE-1:0][DATAWIDTH-1:0]   sa_b_row;
  logic                                      sa_valid_out;
  logic signed [N_SIZE-1:0][2*DATAWIDTH-1:0] sa_c_row;
  logic                                      out_valid;
  logic                                      out_ready;
  logic signed [N_SIZE-1:0][2*DATAWIDTH-1:0] out_c_row;
  logic                                      out_last;
  logic                                      busy;
  logic                                      job_done;
  logic                                      timeout_err;
  logic [15:0]                               job_count;

  // Environment side: host, array and result consumer.
  modport master (
    output in_valid, in_a_row, in_b_row, sa_valid_out, sa_c_row, out_ready,
    input  in_ready, sa_valid_in, sa_a_row, sa_b_row, out_valid, out_c_row,
           out_last, busy, job_done, timeout_err, job_count
  );

  // Controller side.
  modport slave (
    input  in_valid, in_a_row, in_b_row, sa_valid_out, sa_c_row, out_ready,
    output in_ready, sa_valid_in, sa_a_row, sa_b_row, out_valid, out_c_row,
           out_last, busy, job_done, timeout_err, job_count
  );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Job sequencer: buffers one job, feeds the array, collects and drains result rows.
// Latency: last load handshake -> first fed row 1 cycle; last captured row -> out_valid 1 cycle.
// Backpressure: in_ready only while loading; a result row holds on out_c_row until out_ready.
module systolic_array_ctrl #(
  parameter int N_SIZE         = 5,
  parameter int DATAWIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4 * N_SIZE
) (
  input logic                  clk,
  input logic                  rst_n,
  systolic_array_ctrl_if.slave io
);
  localparam int CW = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(N_SIZE - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef logic signed [N_SIZE-1:0][DATAWIDTH-1:0]   ab_row_t;
  typedef logic signed [N_SIZE-1:0][2*DATAWIDTH-1:0] c_row_t;
  typedef enum logic [2:0] {S_LOAD, S_FEED, S_WAIT, S_COLLECT, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] load_cnt, feed_cnt, cap_cnt, drain_cnt, feed_nxt;
  logic [WW-1:0] wdog;
  logic [15:0]   job_count_q;
  logic          sa_vld_q;
  ab_row_t       sa_a_q, sa_b_q;
  ab_row_t       a_buf [N_SIZE];
  ab_row_t       b_buf [N_SIZE];
  c_row_t        c_buf [N_SIZE];

  logic collecting, load_hs, load_last, feed_last, capture, cap_last;
  logic wdog_expire, drain_hs, drain_last;

  assign collecting  = (state_q == S_WAIT) || (state_q == S_COLLECT);
  assign load_hs     = (state_q == S_LOAD) && io.in_valid;
  assign load_last   = load_hs && (load_cnt == LAST_IDX);
  assign feed_last   = (state_q == S_FEED) && (feed_cnt == LAST_IDX);
  assign feed_nxt    = feed_cnt + CW'(1);
  // Array output is only trusted while a job is outstanding.
  assign capture     = collecting && io.sa_valid_out;
  assign cap_last    = capture && (cap_cnt == LAST_IDX);
  // The final capture beats a watchdog expiring on the same cycle.
  assign wdog_expire = collecting && (wdog == WDOG_LAST) && !cap_last;
  assign drain_hs    = (state_q == S_DRAIN) && io.out_ready;
  assign drain_last  = drain_hs && (drain_cnt == LAST_IDX);

  assign io.sa_valid_in = sa_vld_q;
  assign io.sa_a_row    = sa_a_q;
  assign io.sa_b_row    = sa_b_q;
  assign io.job_count   = job_count_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  // Next state plus handshake and status outputs decoded from the current state.
  always_comb begin
    state_d        = state_q;
    io.in_ready    = 1'b0;
    io.busy        = 1'b1;
    io.out_valid   = 1'b0;
    io.out_last    = 1'b0;
    io.out_c_row   = '0;
    io.job_done    = 1'b0;
    io.timeout_err = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        io.in_ready = 1'b1;
        io.busy     = 1'b0;
        if (load_last) state_d = S_FEED;
      end
      S_FEED: begin
        if (feed_last) state_d = S_WAIT;
      end
      S_WAIT, S_COLLECT: begin
        if (cap_last) begin
          state_d = S_DRAIN;
        end else if (wdog_expire) begin
          io.timeout_err = 1'b1;
          state_d        = S_LOAD;
        end else if (capture) begin
          state_d = S_COLLECT;
        end
      end
      S_DRAIN: begin
        io.out_valid = 1'b1;
        io.out_c_row = c_buf[drain_cnt];
        io.out_last  = (drain_cnt == LAST_IDX);
        if (drain_last) begin
          io.job_done = 1'b1;
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Counters, watchdog, registered feed outputs and the completed-job counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt    <= '0;
      feed_cnt    <= '0;
      cap_cnt     <= '0;
      drain_cnt   <= '0;
      wdog        <= '0;
      job_count_q <= '0;
      sa_vld_q    <= 1'b0;
      sa_a_q      <= '0;
      sa_b_q      <= '0;
    end else begin
      if (load_hs) load_cnt <= load_last ? '0 : load_cnt + CW'(1);
      // Row 0 leaves on the cycle after the final load; with one row it is the incoming one.
      if (load_last) begin
        sa_vld_q <= 1'b1;
        sa_a_q   <= (N_SIZE == 1) ? io.in_a_row : a_buf[0];
        sa_b_q   <= (N_SIZE == 1) ? io.in_b_row : b_buf[0];
        feed_cnt <= '0;
      end
      if (state_q == S_FEED) begin
        if (feed_last) begin
          sa_vld_q <= 1'b0;
          sa_a_q   <= '0;
          sa_b_q   <= '0;
          wdog     <= '0;
          cap_cnt  <= '0;
        end else begin
          feed_cnt <= feed_nxt;
          sa_a_q   <= a_buf[feed_nxt];
          sa_b_q   <= b_buf[feed_nxt];
        end
      end
      if (collecting) begin
        wdog <= wdog + WW'(1);
        if (capture) cap_cnt <= cap_last ? '0 : cap_cnt + CW'(1);
      end
      if (drain_hs)   drain_cnt   <= drain_last ? '0 : drain_cnt + CW'(1);
      if (drain_last) job_count_q <= job_count_q + 16'd1;
    end
  end

  // Row buffers carry no reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (load_hs) begin
      a_buf[load_cnt] <= io.in_a_row;
      b_buf[load_cnt] <= io.in_b_row;
    end
    if (capture) c_buf[cap_cnt] <= io.sa_c_row;
  end
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: host, array stub and consumer driven at the falling edge.
// Latency: expectations come from a matrix-product model of the host-loaded job.
// Backpressure: consumer stalls, gappy loads and gappy array output are exercised.
module tb_systolic_array_ctrl;
  localparam int N  = 5;
  localparam int DW = 16;
  localparam int TO = 4 * N;

  typedef logic [N-1:0][DW-1:0]   ab_t;
  typedef logic [N-1:0][2*DW-1:0] c_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_array_ctrl_if #(.N_SIZE(N), .DATAWIDTH(DW)) sif ();

  systolic_array_ctrl #(.N_SIZE(N), .DATAWIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (sif)
  );

  int  n_checks = 0, n_pass = 0, n_fail = 0, cyc = 0;
  ab_t ha[N], hb[N], fa[N], fb[N];
  c_t  exp_c[N];
  c_t  last_row, hold_row;
  c_t  stub_q[$];
  int  ld_idx, ld_mode, nfed, feed_bursts, first_feed_cyc, last_feed_cyc, last_ld_cyc;
  int  stub_mode, stub_wait, stub_sent, gaps_used, last_cap_cyc;
  int  stall_max, stall_cnt, rows_out, first_out_cyc, last_hs_cyc, unstable, nonzero_idle;
  int  done_cnt, done_cyc, to_cnt, to_cyc;
  bit  ld_en, prev_sa_vld, stub_gaps, stub_armed, stray_en, hold_vld;

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input c_t obs, input c_t exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Row i of the product A x B, element widths truncated to 2*DW.
  function automatic c_t mult_row(input ab_t a[N], input ab_t b[N], input int i);
    c_t r;
    int acc;
    for (int j = 0; j < N; j++) begin
      acc = 0;
      for (int k = 0; k < N; k++) acc += int'($signed(a[i][k])) * int'($signed(b[k][j]));
      r[j] = acc;
    end
    return r;
  endfunction

  function automatic ab_t junk_ab();
    ab_t r;
    for (int k = 0; k < N; k++) r[k] = 16'($urandom);
    return r;
  endfunction

  function automatic c_t junk_c();
    c_t r;
    for (int k = 0; k < N; k++) r[k] = $urandom;
    return r;
  endfunction

  // One clock: observe outputs at the falling edge, then drive host, consumer and array stub.
  task automatic tick();
    bit v;
    @(negedge clk);
    cyc++;
    if (sif.sa_valid_in) begin
      if (!prev_sa_vld) begin
        feed_bursts++;
        first_feed_cyc = cyc;
      end
      if (nfed < N) begin
        fa[nfed] = sif.sa_a_row;
        fb[nfed] = sif.sa_b_row;
      end
      nfed++;
      last_feed_cyc = cyc;
    end else if ((sif.sa_a_row | sif.sa_b_row) != '0) begin
      nonzero_idle++;
    end
    prev_sa_vld = sif.sa_valid_in;
    if (sif.out_valid && hold_vld && sif.out_c_row !== hold_row) unstable++;
    if (sif.out_valid && first_out_cyc < 0) first_out_cyc = cyc;

    v = 1'b0;
    if (ld_en && ld_idx < N) begin
      case (ld_mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
    end
    sif.in_valid = v;
    if (v) begin
      sif.in_a_row = ha[ld_idx];
      sif.in_b_row = hb[ld_idx];
    end else begin
      sif.in_a_row = junk_ab();
      sif.in_b_row = junk_ab();
    end
    if (v && sif.in_ready) begin
      ld_idx++;
      last_ld_cyc = cyc;
    end

    if (sif.out_valid && stall_cnt < stall_max) begin
      sif.out_ready = 1'b0;
      stall_cnt++;
    end else begin
      sif.out_ready = 1'b1;
    end
    if (sif.out_valid && sif.out_ready) begin
      if (rows_out < N) begin
        chk_row($sformatf("row%0d", rows_out), sif.out_c_row, exp_c[rows_out]);
        chk_int($sformatf("last%0d", rows_out), int'(sif.out_last), int'(rows_out == N - 1));
      end else begin
        chk_int("extra_row", rows_out, N - 1);
      end
      last_row    = sif.out_c_row;
      rows_out++;
      stall_cnt   = 0;
      last_hs_cyc = cyc;
    end
    hold_vld = sif.out_valid && !sif.out_ready;
    hold_row = sif.out_c_row;

    if (!stub_armed && nfed >= N) begin
      stub_armed = 1'b1;
      for (int i = 0; i < N; i++)
        if (stub_mode == 0 || (stub_mode == 2 && i < 2)) stub_q.push_back(mult_row(fa, fb, i));
      stub_wait = $urandom_range(1, 4);
    end
    sif.sa_valid_out = 1'b0;
    sif.sa_c_row     = junk_c();
    if (stub_wait > 0) begin
      stub_wait--;
    end else if (stub_q.size() > 0) begin
      if (stub_gaps && gaps_used < 6 && $urandom_range(0, 2) == 0) begin
        gaps_used++;
      end else begin
        sif.sa_valid_out = 1'b1;
        sif.sa_c_row     = stub_q.pop_front();
        stub_sent++;
        last_cap_cyc = cyc;
      end
    end else if (stray_en && (sif.in_ready || sif.out_valid) && $urandom_range(0, 1) == 1) begin
      sif.sa_valid_out = 1'b1;
    end

    #1;
    if (sif.job_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (sif.timeout_err) begin
      to_cnt++;
      to_cyc = cyc;
    end
  endtask

  task automatic new_job(input int lmode, input int smax, input int smode, input bit gaps);
    ld_idx = 0; ld_mode = lmode; ld_en = 1'b1;
    stall_max = smax; stall_cnt = 0; hold_vld = 1'b0;
    stub_mode = smode; stub_gaps = gaps; stub_armed = 1'b0; stub_wait = 0;
    stub_sent = 0; gaps_used = 0; stub_q.delete();
    nfed = 0; feed_bursts = 0; rows_out = 0; first_out_cyc = -1;
    done_cnt = 0; to_cnt = 0; unstable = 0; nonzero_idle = 0;
    for (int i = 0; i < N; i++) exp_c[i] = mult_row(ha, hb, i);
  endtask

  task automatic run_job();
    for (int t = 0; t < 400 && done_cnt + to_cnt == 0; t++) tick();
    tick();
    ld_en = 1'b0;
  endtask

  task automatic check_job(input string tag, input int exp_cnt);
    chk_int({tag, "_bursts"}, feed_bursts, 1);
    chk_int({tag, "_fed"}, nfed, N);
    chk_int({tag, "_feed_lat"}, first_feed_cyc - last_ld_cyc, 1);
    chk_int({tag, "_out_lat"}, first_out_cyc - last_cap_cyc, 1);
    chk_int({tag, "_rows"}, rows_out, N);
    chk_int({tag, "_done"}, done_cnt, 1);
    chk_int({tag, "_done_at_last"}, done_cyc, last_hs_cyc);
    chk_int({tag, "_no_timeout"}, to_cnt, 0);
    chk_int({tag, "_stable"}, unstable, 0);
    chk_int({tag, "_idle_zero"}, nonzero_idle, 0);
    chk_int({tag, "_ready_after"}, int'({sif.in_ready, sif.busy}), 2);
    chk_int({tag, "_job_count"}, int'(sif.job_count), exp_cnt);
  endtask

  initial begin
    sif.in_valid = 1'b0; sif.in_a_row = '0; sif.in_b_row = '0;
    sif.sa_valid_out = 1'b0; sif.sa_c_row = '0; sif.out_ready = 1'b0;
    ld_en = 1'b0; stray_en = 1'b0; prev_sa_vld = 1'b0; stub_q.delete();
    stub_wait = 0; nfed = 0; stub_armed = 1'b1; first_out_cyc = -1;

    // Reset state.
    #2;
    chk_int("rst_flags", int'({sif.in_ready, sif.busy, sif.sa_valid_in, sif.out_valid,
                               sif.out_last, sif.job_done, sif.timeout_err}), 64);
    chk_int("rst_count", int'(sif.job_count), 0);
    chk_row("rst_out_row", sif.out_c_row, '0);
    chk_int("rst_sa_rows", int'((sif.sa_a_row | sif.sa_b_row) != '0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic job: all 2 times all 3 gives 30 everywhere.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ha[i][k] = 16'd2;
        hb[i][k] = 16'd3;
      end
    new_job(0, 0, 0, 1'b0);
    run_job();
    check_job("basic", 1);
    chk_int("basic_elem", int'(last_row[3]), 30);

    // Identity A returns B unchanged.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ha[i][k] = (i == k) ? 16'd1 : 16'd0;
        hb[i][k] = 16'(5 * i + k + 1);
      end
    new_job(0, 0, 0, 1'b0);
    run_job();
    check_job("ident", 2);
    chk_int("ident_row4_first", int'(last_row[0]), 21);
    chk_int("ident_row4_lastel", int'(last_row[4]), 25);

    // Gappy load, stalled consumer, gappy array output.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ha[i][k] = 16'($urandom);
        hb[i][k] = 16'($urandom);
      end
    new_job(1, 3, 0, 1'b1);
    run_job();
    check_job("bp", 3);

    // Randomized jobs with stray array pulses while idle or draining.
    stray_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++) begin
          ha[i][k] = 16'($urandom);
          hb[i][k] = 16'($urandom);
        end
      new_job(2, $urandom_range(0, 2), 0, 1'b1);
      run_job();
      check_job($sformatf("rand%0d", j), 4 + j);
    end

    // Stray pulses while idle leave the controller in LOAD.
    for (int t = 0; t < 8; t++) tick();
    chk_int("stray_idle", int'({sif.in_ready, sif.busy, sif.out_valid}), 4);

    // Array never answers: watchdog abort.
    new_job(0, 0, 1, 1'b0);
    run_job();
    chk_int("to_pulses", to_cnt, 1);
    chk_int("to_delay", to_cyc - last_feed_cyc, TO);
    chk_int("to_no_done", done_cnt, 0);
    chk_int("to_no_rows", rows_out, 0);
    chk_int("to_ready_after", int'({sif.in_ready, sif.busy}), 2);
    chk_int("to_job_count", int'(sif.job_count), 6);

    // Reset in COLLECT after two captured rows.
    new_job(0, 0, 2, 1'b0);
    for (int t = 0; t < 100 && stub_sent < 2; t++) tick();
    tick();
    tick();
    ld_en = 1'b0;
    chk_int("mid_collect", int'({sif.in_ready, sif.busy, sif.out_valid}), 2);
    #1 rst_n = 1'b0;
    #1;
    chk_int("mid_rst_flags", int'({sif.in_ready, sif.busy, sif.sa_valid_in, sif.out_valid,
                                   sif.out_last, sif.job_done, sif.timeout_err}), 64);
    chk_int("mid_rst_count", int'(sif.job_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_sa_vld = 1'b0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ha[i][k] = 16'($urandom);
        hb[i][k] = 16'($urandom);
      end
    new_job(2, 1, 0, 1'b1);
    run_job();
    check_job("post_rst", 1);

    // Counter wrap from 0xFFFF.
    @(negedge clk);
    force dut.job_count_q = 16'hFFFF;
    tick();
    release dut.job_count_q;
    tick();
    chk_int("wrap_preload", int'(sif.job_count), 65535);
    new_job(0, 0, 0, 1'b1);
    run_job();
    check_job("wrap", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
Job sequencer in front of systolic_array.
- Accepts one N_SIZE x N_SIZE matrix-multiply job as N_SIZE row pairs (A row, B row) over a valid/ready load interface and buffers them.
- Streams the rows into the array on N_SIZE consecutive cycles, then captures the N_SIZE result rows into a result buffer.
- Drains the results over a valid/ready output interface with backpressure, and guards the array with a result watchdog.

Parameters:
N_SIZE, 5, matrix dimension; number of rows per job.
DATAWIDTH, 16, signed element width of A and B; C elements are 2*DATAWIDTH.
TIMEOUT_CYCLES, 4*N_SIZE, maximum cycles from the last fed row to the N_SIZE-th captured result row.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  host row pair valid
in_ready  out  1  controller can accept a row pair
in_a_row  in  N_SIZE x DATAWIDTH signed  A row
in_b_row  in  N_SIZE x DATAWIDTH signed  B row
sa_valid_in  out  1  to systolic_array valid_in
sa_a_row  out  N_SIZE x DATAWIDTH signed  to matrix_a_in
sa_b_row  out  N_SIZE x DATAWIDTH signed  to matrix_b_in
sa_valid_out  in  1  from systolic_array valid_out
sa_c_row  in  N_SIZE x 2*DATAWIDTH signed  from matrix_c_out
out_valid  out  1  result row valid
out_ready  in  1  consumer accepts result row
out_c_row  out  N_SIZE x 2*DATAWIDTH signed  result row
out_last  out  1  marks row N_SIZE-1 of a job
busy  out  1  high in every state except LOAD
job_done  out  1  one-cycle pulse on last result handshake
timeout_err  out  1  one-cycle pulse on watchdog abort
job_count  out  16  completed jobs, wraps 0xFFFF->0

Behaviour:
- Single clock domain. Reset is asynchronous, active-low, and applies in any state:
  - state becomes LOAD, all counters become 0
  - every output becomes 0 except in_ready, which is 1
  - buffers need not be cleared
- Rows pass through index-for-index. Element k of in_a_row is presented as element k of sa_a_row; the same holds for B and C. No arithmetic in the controller.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready writes A/B buffer[load_cnt] and increments load_cnt.
  - The handshake with load_cnt==N_SIZE-1 moves to FEED next cycle and clears load_cnt.
  - Partial loads persist indefinitely.
- FEED:
  - in_ready=0.
  - Registered outputs: sa_valid_in=1 for exactly N_SIZE consecutive cycles, carrying buffer rows 0..N_SIZE-1 in order.
  - The first fed row appears on the cycle after the last load handshake.
  - After the last row, sa_valid_in=0 and the sa_a_row/sa_b_row outputs return to 0. State moves to WAIT and the watchdog clears.
- WAIT / COLLECT:
  - The watchdog increments every cycle.
  - Each cycle with sa_valid_out=1 writes sa_c_row to result buffer[cap_cnt] and increments cap_cnt. Gaps between captures are allowed; the first capture moves WAIT to COLLECT.
  - The capture with cap_cnt==N_SIZE-1 moves to DRAIN.
  - If the watchdog reaches TIMEOUT_CYCLES before that capture:
    - pulse timeout_err
    - discard the job; job_count unchanged
    - return to LOAD
  - A capture on the same cycle as the timeout wins, and no error is raised.
- sa_valid_out is ignored in LOAD, FEED and DRAIN. Stray rows are never buffered.
- DRAIN:
  - out_valid=1; out_c_row=result buffer[drain_cnt]; out_last=(drain_cnt==N_SIZE-1).
  - out_c_row is stable while out_valid=1 and out_ready=0.
  - Each out_ready handshake increments drain_cnt.
  - On the last handshake: pulse job_done, increment job_count, return to LOAD. in_ready=1 on the following cycle.
  - No timeout applies in DRAIN.
- Only one job is in flight at a time. Loading for the next job starts after the drain completes.
- Latency: last load handshake to first sa_valid_in is 1 cycle; last capture to out_valid is 1 cycle.

Test Plan:
- Basic job: N_SIZE=5, all A elements 2, all B elements 3, in_valid held high, out_ready=1.
  - sa_valid_in is high for exactly 5 consecutive cycles.
  - 5 out rows, every element 30; out_last on row 4; job_done pulse; job_count=1.
- Identity: A=identity, B rows b[k][j]=5k+j+1.
  - Result rows equal the B rows exactly: row 0=[1..5], row 4=[21..25].
- Backpressure and gappy load:
  - in_valid toggled 1/0 during load: sa_valid_in still appears as a contiguous 5-cycle burst.
  - out_ready low 3 cycles per row: out_c_row stays stable and no row is lost or duplicated.
- Timeout: stub array never asserts sa_valid_out.
  - timeout_err pulses exactly 20 cycles after the last fed row; state returns to LOAD; job_count unchanged.
- Reset mid-job: assert rst_n=0 during COLLECT with 2 rows captured.
  - All outputs drop immediately to reset values.
  - A new full job then completes correctly with job_count=1.
- Stray output and wrap: sa_valid_out pulsed in LOAD has no effect.
  - Preload job_count to 0xFFFF (force), finish a job: job_count=0.
